// File: rtl/ysyx_23060191_mc_pkg.sv
// Shared types and defaults for the ysyx_23060191 multi-cycle sequencer.
package ysyx_23060191_mc_pkg;

   typedef enum logic [2:0] {
      S_IF, S_IF_W, S_EX, S_LS, S_LS_W, S_WB, S_HALT, S_FAULT
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_IFETCH  = 2'd0,
      CAUSE_DMEM    = 2'd1,
      CAUSE_ILLEGAL = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } cause_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
   localparam int          DEFAULT_TIMEOUT  = 255;

   // HALT and FAULT are absorbing; everything else is live and counts cycles.
   function automatic logic is_live(input state_e s);
      return !(s inside {S_HALT, S_FAULT});
   endfunction

endpackage

// File: rtl/ysyx_23060191_wait_timer.sv
// Response wait counter: cleared outside wait states, flags the cycle whose
// increment would reach TIMEOUT so the FSM can leave on that same edge.
module ysyx_23060191_wait_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !hit) begin
         count <= count + CW'(1);
      end
   end

   assign hit = (TIMEOUT != 0) && en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_23060191_mc_ctrl.sv
// Multi-cycle sequencer: owns PC, IR and retire; talks to imem/dmem over
// valid/ready request and response channels with arbitrary latency.
module ysyx_23060191_mc_ctrl
   import ysyx_23060191_mc_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC,
   parameter int               TIMEOUT  = DEFAULT_TIMEOUT,
   parameter int               CNT_W    = 64
) (
   input  logic              clk,
   input  logic              rstn,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   input  logic              imem_rsp_err,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic [XLEN-1:0]   dmem_req_addr,
   output logic              dmem_req_wen,
   output logic [XLEN-1:0]   dmem_req_wdata,
   output logic [XLEN/8-1:0] dmem_req_wmask,
   input  logic              dmem_rsp_valid,
   input  logic [XLEN-1:0]   dmem_rsp_data,
   input  logic              dmem_rsp_err,
   input  logic              dec_is_load,
   input  logic              dec_is_store,
   input  logic              dec_is_ebreak,
   input  logic              dec_illegal,
   input  logic              dec_wr_en_Rd,
   input  logic [XLEN/8-1:0] dec_lsu_mask,
   input  logic [XLEN-1:0]   exu_res,
   input  logic [XLEN-1:0]   data_Rs2,
   input  logic [XLEN-1:0]   next_pc,
   output logic [XLEN-1:0]   pc,
   output logic [31:0]       inst,
   output logic [XLEN-1:0]   load_data,
   output logic              gpr_wen,
   output logic              retire,
   output logic              halted,
   output logic              fault,
   output logic [1:0]        fault_cause,
   output logic [CNT_W-1:0]  mcycle,
   output logic [CNT_W-1:0]  minstret
);

   state_e state;
   logic   waiting;
   logic   rsp_seen;
   logic   timeout_hit;
   logic   wb_gpr_wen;

   assign imem_req_addr = pc;
   assign waiting       = (state == S_IF_W) || (state == S_LS_W);
   assign rsp_seen      = (state == S_IF_W) ? imem_rsp_valid : dmem_rsp_valid;
   // Stores never write the register file even if the decoder flags Rd.
   assign wb_gpr_wen    = dec_wr_en_Rd && !dec_is_store;

   ysyx_23060191_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk  (clk),
      .rstn (rstn),
      .clr  (!waiting),
      .en   (waiting && !rsp_seen),
      .hit  (timeout_hit)
   );

   // NOTE: every register in this block uses <= so all updates on an edge see
   // the pre-edge values; a blocking = here would create ordering-dependent logic.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= S_IF;
         pc             <= RESET_PC;
         inst           <= '0;
         load_data      <= '0;
         imem_req_valid <= 1'b0;
         dmem_req_valid <= 1'b0;
         dmem_req_addr  <= '0;
         dmem_req_wen   <= 1'b0;
         dmem_req_wdata <= '0;
         dmem_req_wmask <= '0;
         gpr_wen        <= 1'b0;
         retire         <= 1'b0;
         halted         <= 1'b0;
         fault          <= 1'b0;
         fault_cause    <= CAUSE_IFETCH;
         mcycle         <= '0;
         minstret       <= '0;
      end else begin
         gpr_wen <= 1'b0;
         retire  <= 1'b0;
         if (is_live(state)) begin
            mcycle <= mcycle + CNT_W'(1);
         end

         unique case (state)
            S_IF: begin
               // Valid rises one cycle after reset release, then is held until accepted.
               if (!imem_req_valid) begin
                  imem_req_valid <= 1'b1;
               end else if (imem_req_ready) begin
                  imem_req_valid <= 1'b0;
                  state          <= S_IF_W;
               end
            end

            S_IF_W: begin
               if (imem_rsp_valid) begin
                  inst <= imem_rsp_data;
                  if (imem_rsp_err) begin
                     state       <= S_FAULT;
                     fault       <= 1'b1;
                     fault_cause <= CAUSE_IFETCH;
                  end else begin
                     state <= S_EX;
                  end
               end else if (timeout_hit) begin
                  state       <= S_FAULT;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_TIMEOUT;
               end
            end

            S_EX: begin
               if (dec_illegal) begin
                  state       <= S_FAULT;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_ILLEGAL;
               end else if (dec_is_ebreak) begin
                  state    <= S_HALT;
                  halted   <= 1'b1;
                  retire   <= 1'b1;
                  minstret <= minstret + CNT_W'(1);
               end else if (dec_is_load || dec_is_store) begin
                  state          <= S_LS;
                  dmem_req_valid <= 1'b1;
                  dmem_req_addr  <= exu_res;
                  dmem_req_wen   <= dec_is_store;
                  dmem_req_wdata <= data_Rs2;
                  dmem_req_wmask <= dec_lsu_mask;
               end else begin
                  state    <= S_WB;
                  gpr_wen  <= wb_gpr_wen;
                  retire   <= 1'b1;
                  minstret <= minstret + CNT_W'(1);
               end
            end

            S_LS: begin
               if (dmem_req_ready) begin
                  dmem_req_valid <= 1'b0;
                  state          <= S_LS_W;
               end
            end

            S_LS_W: begin
               if (dmem_rsp_valid) begin
                  load_data <= dmem_rsp_data;
                  if (dmem_rsp_err) begin
                     state       <= S_FAULT;
                     fault       <= 1'b1;
                     fault_cause <= CAUSE_DMEM;
                  end else begin
                     state    <= S_WB;
                     gpr_wen  <= wb_gpr_wen;
                     retire   <= 1'b1;
                     minstret <= minstret + CNT_W'(1);
                  end
               end else if (timeout_hit) begin
                  state       <= S_FAULT;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_TIMEOUT;
               end
            end

            S_WB: begin
               pc             <= next_pc;
               imem_req_valid <= 1'b1;
               state          <= S_IF;
            end

            S_HALT, S_FAULT: begin
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/ysyx_23060191_mc_ctrl.md
# ysyx_23060191_mc_ctrl

Multi-cycle sequencer for the ysyx_23060191 core. It replaces the single-cycle "one instruction per clock" top with a state machine that owns the PC, the instruction register and the retire handshake. It talks to instruction and data memories over valid/ready request/response channels, so memories with arbitrary latency can be attached. Existing combinational IDU/EXU/WBU logic connects to its decode-side ports; it gates GPR writes and detects EBREAK/fault halts in hardware.

## Interface
Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 255, max cycles waiting on any response before FAULT (0 disables)
- CNT_W, 64, width of cycle/instret counters

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  fetch accepted
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  fetch data valid
- imem_rsp_data  in  32  instruction
- imem_rsp_err  in  1  fetch bus error
- dmem_req_valid  out  1  load/store request
- dmem_req_ready  in  1  request accepted
- dmem_req_addr  out  XLEN  = exu_res latched
- dmem_req_wen  out  1  1 = store
- dmem_req_wdata  out  XLEN  store data (data_Rs2 latched)
- dmem_req_wmask  out  XLEN/8  byte strobes from dec_lsu_mask
- dmem_rsp_valid  in  1  response valid (load data or store ack)
- dmem_rsp_data  in  XLEN  load data
- dmem_rsp_err  in  1  bus error
- dec_is_load / dec_is_store / dec_is_ebreak / dec_illegal / dec_wr_en_Rd  in  1 each  IDU flags for current inst
- dec_lsu_mask  in  XLEN/8  byte strobes
- exu_res  in  XLEN  EXU result/address
- data_Rs2  in  XLEN  store data
- next_pc  in  XLEN  PCU-computed next PC
- pc  out  XLEN  current PC
- inst  out  32  instruction register
- load_data  out  XLEN  latched load data to WBU
- gpr_wen  out  1  GPR write strobe, one cycle
- retire  out  1  one-cycle pulse per committed instruction
- halted  out  1  EBREAK reached
- fault  out  1  fault state; fault_cause out 2: 0 ifetch err, 1 dmem err, 2 illegal, 3 timeout
- mcycle / minstret  out  CNT_W  counters

## Operation
- States: IF, IF_W, EX, LS, LS_W, WB, HALT, FAULT.
- IF: imem_req_valid=1; on imem_req_ready go IF_W.
- IF_W: on imem_rsp_valid latch inst; err → FAULT(0); else EX.
- EX: one cycle; decode flags valid. Transitions:
  - dec_illegal → FAULT(2).
  - dec_is_ebreak → HALT, retire=1.
  - load/store → LS, latching addr, wdata, wmask, wen.
  - else → WB.
- LS: dmem_req_valid=1 until dmem_req_ready → LS_W.
- LS_W: on dmem_rsp_valid latch load_data; err → FAULT(1); else WB.
- WB: gpr_wen = dec_wr_en_Rd & !dec_is_store; pc ← next_pc; retire=1; minstret++; → IF.
- Request outputs are held stable while valid and not ready; valid never drops without acceptance.
- Wait counter clears on entry to IF_W/LS_W and increments each waiting cycle. When TIMEOUT≠0 and count reaches TIMEOUT → FAULT(3).
- HALT/FAULT are absorbing until reset. mcycle stops counting in them.
- inst, exu_res and next_pc are assumed stable from EX through WB because the IR is held. Store data and address are latched at EX exit.

## Timing
- Reset (async assert, any state): state=IF, pc=RESET_PC, inst=0, load_data=0, all valids/strobes/flags=0, fault_cause=0, counters=0. The first request is issued the cycle after rstn deasserts.
- ALU instruction with zero-wait memory (ready and rsp in the cycle after req): IF→IF_W→EX→WB, 4 cycles. Load/store: 6 cycles.
- rsp arriving in the same cycle as req acceptance is not allowed. Responses are only sampled in IF_W/LS_W.
- mcycle increments every non-halted, non-reset cycle. minstret increments with retire, including EBREAK.
- Reset mid-transaction discards it. Memories must tolerate the abandoned request.

## Structure
- Package ysyx_23060191_mc_pkg: state enum (3-bit), fault-cause encodings, default RESET_PC.
- One sub-module, ysyx_23060191_wait_timer: counter with clear/enable and TIMEOUT compare.

## Test plan
- Reset release, imem zero-wait, `addi x1,x0,5` then EBREAK at 0x8000_0004 → pc 0x8000_0000→0x8000_0004, gpr_wen once, halted=1, minstret=2.
- imem_req_ready delayed 3 cycles → addr/valid held stable, single fetch, ALU instruction retires in 7 cycles.
- `sw` to 0x8000_1000 with mask 4'b1111, data 0xDEADBEEF → dmem_req_wen=1 with those values, gpr_wen=0.
- `lw` with rsp after 5 cycles with 0x1234_5678 → load_data=0x1234_5678, gpr_wen pulse in WB.
- dmem_rsp_err=1 → fault=1, fault_cause=1, no retire. Separately, imem never responds with TIMEOUT=255 → FAULT(3) after 255 wait cycles.
- rstn asserted during LS_W → outputs at reset values immediately, refetch from RESET_PC.
